// File: rtl/button_events.sv
// rtl/button_events.sv - synchronise, debounce, press/auto-repeat detect and latch push-button events
module button_events #(
  parameter int TICK_DIV      = 65536,
  parameter int REPEAT_DELAY  = 240,
  parameter int REPEAT_PERIOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] buttons_in,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_guess,
  output logic       btn_soft_new,
  output logic       btn_hard_new,
  output logic       btn_peek,
  output logic       btn_roll,
  output logic       btn_any,
  input  logic       ack_up,
  input  logic       ack_down,
  input  logic       ack_left,
  input  logic       ack_right,
  input  logic       ack_guess,
  input  logic       ack_soft_new,
  input  logic       ack_hard_new,
  input  logic       ack_peek,
  input  logic       ack_roll,
  input  logic       ack_any
);

  localparam int NB = 9;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [NB-1:0]      sync1;
  logic [NB-1:0]      s;
  logic [TW-1:0]      tcnt;
  logic               tick;
  logic [NB-1:0][2:0] hist;
  logic [NB-1:0][2:0] hn;
  logic [NB-1:0]      st;
  logic [NB-1:0]      st_next;
  logic [NB-1:0]      pev;
  logic [3:0]         rev;
  logic [3:0]         dprev;
  logic [RW-1:0]      rcnt;
  logic [RW-1:0]      rcnt_next;
  logic [NB-1:0]      evt;
  logic [NB-1:0]      ack;
  logic [NB-1:0]      pend;
  logic               any;

  assign ack = {ack_roll, ack_peek, ack_hard_new, ack_soft_new, ack_guess,
                ack_right, ack_left, ack_down, ack_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= buttons_in;
      s     <= sync1;
    end
  end

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // A level only flips after three identical tick samples.
  always_comb begin
    hn      = '0;
    st_next = st;
    for (int i = 0; i < NB; i++) begin
      hn[i] = {hist[i][1:0], s[i]};
      if (hn[i] == 3'b111) begin
        st_next[i] = 1'b1;
      end else if (hn[i] == 3'b000) begin
        st_next[i] = 1'b0;
      end
    end
  end

  assign pev = {NB{tick}} & st_next & ~st;

  // One shared repeat timer; any change in the held direction set restarts it.
  always_comb begin
    rcnt_next = rcnt;
    rev       = '0;
    if (tick) begin
      if ((st_next[3:0] == 4'b0000) || (st_next[3:0] != dprev)) begin
        rcnt_next = '0;
      end else if (rcnt == RPT_LAST) begin
        rev       = st_next[3:0];
        rcnt_next = RPT_RELOAD;
      end else begin
        rcnt_next = rcnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      st    <= '0;
      dprev <= '0;
      rcnt  <= '0;
    end else if (tick) begin
      hist  <= hn;
      st    <= st_next;
      dprev <= st_next[3:0];
      rcnt  <= rcnt_next;
    end
  end

  assign evt = pev | {5'b00000, rev};

  // The set term dominates so an event landing with its ack is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      any  <= 1'b0;
    end else begin
      pend <= (pend & ~ack) | evt;
      any  <= (any & ~ack_any) | (|evt);
    end
  end

  assign btn_up       = pend[0];
  assign btn_down     = pend[1];
  assign btn_left     = pend[2];
  assign btn_right    = pend[3];
  assign btn_guess    = pend[4];
  assign btn_soft_new = pend[5];
  assign btn_hard_new = pend[6];
  assign btn_peek     = pend[7];
  assign btn_roll     = pend[8];
  assign btn_any      = any;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - directed self-checking bench for button_events
module tb_button_events;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] buttons_in;
  logic [9:0] acks;
  logic       btn_up, btn_down, btn_left, btn_right, btn_guess;
  logic       btn_soft_new, btn_hard_new, btn_peek, btn_roll, btn_any;
  logic [9:0] outs;
  int         cyc;
  int         n_checks = 0;
  int         n_errors = 0;

  localparam logic [9:0] A_UP    = 10'h001;
  localparam logic [9:0] A_DOWN  = 10'h002;
  localparam logic [9:0] A_LEFT  = 10'h004;
  localparam logic [9:0] A_RIGHT = 10'h008;
  localparam logic [9:0] A_GUESS = 10'h010;
  localparam logic [9:0] A_PEEK  = 10'h080;
  localparam logic [9:0] A_ROLL  = 10'h100;
  localparam logic [9:0] A_ANY   = 10'h200;

  always #5 clk = ~clk;

  button_events #(
    .TICK_DIV      (4),
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons_in   (buttons_in),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_guess    (btn_guess),
    .btn_soft_new (btn_soft_new),
    .btn_hard_new (btn_hard_new),
    .btn_peek     (btn_peek),
    .btn_roll     (btn_roll),
    .btn_any      (btn_any),
    .ack_up       (acks[0]),
    .ack_down     (acks[1]),
    .ack_left     (acks[2]),
    .ack_right    (acks[3]),
    .ack_guess    (acks[4]),
    .ack_soft_new (acks[5]),
    .ack_hard_new (acks[6]),
    .ack_peek     (acks[7]),
    .ack_roll     (acks[8]),
    .ack_any      (acks[9])
  );

  assign outs = {btn_any, btn_roll, btn_peek, btn_hard_new, btn_soft_new,
                 btn_guess, btn_right, btn_left, btn_down, btn_up};

  // Clock count since reset release; the debounce tick edge leaves cyc a multiple of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_tick();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) next_tick();
  endtask

  task automatic wait_pre_tick();
    do @(negedge clk); while (cyc % 4 != 3);
  endtask

  task automatic ack_mask(input logic [9:0] m);
    acks = m;
    @(negedge clk);
    acks = '0;
  endtask

  logic [4:0]  bounce   = 5'b01101;
  logic [18:0] rpt_exp  = 19'h01508;
  logic [17:0] up_exp   = 18'h05008;
  logic [17:0] left_exp = 18'h05080;

  initial begin
    rst_n      = 1'b0;
    buttons_in = '0;
    acks       = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_outs", outs, 0);
    next_tick();

    // clean press on guess
    buttons_in[4] = 1'b1;
    next_tick();
    check_eq("guess_t1", btn_guess, 0);
    next_tick();
    check_eq("guess_t2", btn_guess, 0);
    wait_pre_tick();
    check_eq("guess_pre_t3", btn_guess, 0);
    next_tick();
    check_eq("guess_press", btn_guess, 1);
    check_eq("any_press", btn_any, 1);
    ack_mask(A_GUESS);
    check_eq("guess_acked", btn_guess, 0);
    check_eq("any_not_acked", btn_any, 1);
    ack_mask(A_ANY);
    check_eq("any_acked", btn_any, 0);
    ticks(3);
    check_eq("guess_held_no_event", outs, 0);
    buttons_in[4] = 1'b0;
    ticks(4);
    check_eq("guess_release", outs, 0);

    // bounce on roll
    for (int i = 0; i < 5; i++) begin
      buttons_in[8] = bounce[i];
      next_tick();
      check_eq($sformatf("bounce_%0d", i), btn_roll, 0);
    end
    buttons_in[8] = 1'b1;
    next_tick();
    check_eq("roll_s1", btn_roll, 0);
    next_tick();
    check_eq("roll_s2", btn_roll, 0);
    next_tick();
    check_eq("roll_press", btn_roll, 1);
    ack_mask(A_ROLL | A_ANY);
    check_eq("roll_acked", outs, 0);
    ticks(2);
    check_eq("roll_single_event", outs, 0);
    buttons_in[8] = 1'b0;
    ticks(3);

    // ack racing a fresh press on peek
    buttons_in[7] = 1'b1;
    ticks(3);
    check_eq("peek_press", btn_peek, 1);
    buttons_in[7] = 1'b0;
    ticks(3);
    check_eq("peek_still_pending", btn_peek, 1);
    buttons_in[7] = 1'b1;
    ticks(2);
    wait_pre_tick();
    ack_mask(A_PEEK);
    check_eq("peek_ack_race", btn_peek, 1);
    ack_mask(A_PEEK);
    check_eq("peek_ack", btn_peek, 0);
    ack_mask(A_ANY);
    buttons_in[7] = 1'b0;
    ticks(3);
    check_eq("peek_idle", outs, 0);

    // auto-repeat on right: press at 3, repeats 8,10,12, debounce tail ends at 12
    buttons_in[3] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      next_tick();
      check_eq($sformatf("rpt_right_k%0d", k), btn_right, rpt_exp[k]);
      if (k == 10) buttons_in[3] = 1'b0;
      if (btn_right) ack_mask(A_RIGHT | A_ANY);
    end
    ack_mask(A_ANY);

    // up held, left joins: left press at 7, joint repeats at 12 and 14 (release tail)
    buttons_in[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      next_tick();
      check_eq($sformatf("dir2_up_k%0d", k), btn_up, up_exp[k]);
      check_eq($sformatf("dir2_left_k%0d", k), btn_left, left_exp[k]);
      if (k == 4) buttons_in[2] = 1'b1;
      if (k == 12) begin
        buttons_in[0] = 1'b0;
        buttons_in[2] = 1'b0;
      end
      if (btn_up || btn_left) ack_mask(A_UP | A_LEFT | A_ANY);
    end
    ack_mask(A_ANY);

    // reset while down is pending and held
    buttons_in[1] = 1'b1;
    ticks(3);
    check_eq("down_press", btn_down, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs", outs, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_outs", outs, 0);
    next_tick();
    check_eq("down_rst_t1", btn_down, 0);
    next_tick();
    check_eq("down_rst_t2", btn_down, 0);
    next_tick();
    check_eq("down_rst_t3", btn_down, 1);
    check_eq("any_rst_t3", btn_any, 1);
    ack_mask(A_DOWN | A_ANY);
    check_eq("down_final_ack", outs, 0);
    buttons_in = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Front-end input stage that turns raw, bouncy push-button levels into one-shot press events for the game logic. Per button it synchronises, debounces on a shared prescaled tick and detects presses; the four direction buttons also auto-repeat while held. Each event is held on its `btn_*` output until the matching `ack_*` arrives, and `btn_any` flags any event at all. Outputs connect directly to the `btn_*`/`ack_*` pairs of the game top level.

## Interface

Parameters:
- `TICK_DIV`, default 65536: clock cycles per debounce sample tick (≥2).
- `REPEAT_DELAY`, default 240: ticks a direction must be held before the first repeat (≥1).
- `REPEAT_PERIOD`, default 60: ticks between subsequent repeats (1..REPEAT_DELAY).

Ports:
- `clk`, in, 1: system clock (single clock domain).
- `rst_n`, in, 1: asynchronous active-low reset.
- `buttons_in`, in, 9: raw button levels, active-high, asynchronous.
  - Bit order: 0 up, 1 down, 2 left, 3 right, 4 guess, 5 soft_new, 6 hard_new, 7 peek, 8 roll.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_guess`, `btn_soft_new`, `btn_hard_new`, `btn_peek`, `btn_roll`, out, 1 each: pending press event.
- `btn_any`, out, 1: pending "some event occurred" flag.
- `ack_up` … `ack_roll`, `ack_any`, in, 1 each: clear the corresponding pending flag.

## Operation

- **Synchroniser:** two flops per bit, reset 0. `s[i]` is the second-stage output.
- **Prescaler:**
  - `tcnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (`tcnt` == TICK_DIV-1).
- **Debounce** (per bit, updated only on `tick` edges):
  - `hist[i]` (3 bits, reset 000) shifts in `s[i]`; call the result `hn`.
  - Stable level `st[i]` (reset 0) becomes 1 when `hn`==111, becomes 0 when `hn`==000, otherwise holds.
- **Press event:** `pev[i]` = `tick` & next `st[i]` & ~`st[i]`, i.e. a 0→1 transition of `st`. Release generates no event.
- **Auto-repeat** (bits 0..3 only):
  - Shared counter `rcnt`, width clog2(REPEAT_DELAY+1), reset 0. Register `dprev` holds the last `st[3:0]`.
  - On a `tick` edge:
    - If next `st[3:0]` is 0 or differs from `dprev`, `rcnt` ← 0.
    - Else if `rcnt` == REPEAT_DELAY-1: repeat event `rev[i]` fires for every held direction `i`, and `rcnt` ← REPEAT_DELAY-REPEAT_PERIOD.
    - Else `rcnt` ← `rcnt`+1.
  - `dprev` is updated on every `tick` edge.
  - Holding one direction and pressing a second restarts the delay; the new press still emits its own `pev`.
- **Pending latches** (every clock):
  - `pend[i]` ← (`pend[i]` & ~`ack[i]`) | `pev[i]` | `rev[i]`.
  - `any` ← (`any` & ~`ack_any`) | OR of all `pev`/`rev`.
  - An event and its ack in the same cycle leave the flag set; the set term wins, so no event is lost.
  - A press while already pending is merged: the flag stays 1 and there is no counter.
  - Acks to flags that are not pending are ignored.
- **Outputs:** `btn_*` = `pend`, `btn_any` = `any`, all driven directly from flops.
- **Reset mid-operation:** everything clears asynchronously. After release, a still-held button must be seen as three fresh 1 samples, then produces exactly one press event.

## Timing

- All outputs are 0 during and immediately after reset.
- **Latency:**
  - A raw level is visible on `s` 2 clocks after it settles.
  - `pend` sets on the `tick` edge that samples the third consecutive 1.
  - `btn_x` is high in the cycle after that edge.
  - Worst-case press latency is 2 + 3·TICK_DIV clocks.
- **Ack:** `btn_x` drops the cycle after `ack_x` is sampled high, unless a new event for the same bit lands on that same edge.
- **Glitch rejection:** any run of fewer than 3 identical tick samples never changes `st`.
- **Repeat cadence:** the first repeat fires REPEAT_DELAY ticks after the press tick; later repeats fire every REPEAT_PERIOD ticks.
- **Wrap:**
  - `tcnt` wraps silently.
  - `rcnt` never exceeds REPEAT_DELAY-1.

## Test plan

All scenarios use TICK_DIV=4, REPEAT_DELAY=5, REPEAT_PERIOD=2.

- **Clean press:** hold `buttons_in[4]`=1 across 3 ticks, never ack → `btn_guess` and `btn_any` rise the cycle after the 3rd tick edge; no second event while held; release → nothing new.
- **Bounce:** on bit 8, toggle 1,0,1,1,0 sampled on successive ticks → `btn_roll` stays 0; then three 1 samples → exactly one event.
- **Ack race:** pending `btn_peek`; assert `ack_peek` on the same edge a fresh `pev[7]` fires → `btn_peek` remains 1; ack again → 0 the next cycle.
- **Auto-repeat:**
  - Hold right, acking each event the cycle it appears.
  - Required: events at press tick P, then at P+5, P+7, P+9 ticks.
  - Release → no more events.
- **Second direction:** holding up, press left at tick T → left `pev` at T; next repeat (up and left together) at T+5; up's earlier schedule is abandoned.
- **Reset mid-hold:** assert `rst_n`=0 while `btn_down` is pending and the button is held → all outputs 0 immediately; after deassert, `btn_down` returns after 3 more ticks.
